// File: rtl/wpa2_nios2_mul_unit.sv
// +----------------------------------------------------------------------------+
// | wpa2_nios2_mul_unit: two-stage DATA_W x DATA_W multiplier, four flavours    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module wpa2_nios2_mul_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_valid,
  input  logic [1:0]        E_op,
  input  logic              M_en,
  input  logic              M_flush,
  output logic [DATA_W-1:0] W_mul_result,
  output logic              W_mul_valid,
  output logic              W_mul_busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  // Stage 1 state
  logic [DATA_W-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [DATA_W-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [DATA_W-1:0] a_q, b_q, a_d, b_d;
  logic [1:0]        op_q, op_d;
  logic              a_neg_q, b_neg_q, a_neg_d, b_neg_d;
  logic              s1_valid_q, s1_valid_d;

  // Stage 2 state
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [PROD_W-1:0] uu, corr_a, corr_b, full;
  logic [DATA_W-1:0] sel_word;

  assign a_lo = E_src1[HALF_W-1:0];
  assign a_hi = E_src1[DATA_W-1:HALF_W];
  assign b_lo = E_src2[HALF_W-1:0];
  assign b_hi = E_src2[DATA_W-1:HALF_W];

  // Unsigned product from partials, then subtract 2^DATA_W * other operand
  // for each operand treated as signed with its MSB set.
  assign uu = {{DATA_W{1'b0}}, pp_ll_q}
            + {{HALF_W{1'b0}}, pp_lh_q, {HALF_W{1'b0}}}
            + {{HALF_W{1'b0}}, pp_hl_q, {HALF_W{1'b0}}}
            + {pp_hh_q, {DATA_W{1'b0}}};
  assign corr_a   = a_neg_q ? {b_q, {DATA_W{1'b0}}} : '0;
  assign corr_b   = b_neg_q ? {a_q, {DATA_W{1'b0}}} : '0;
  assign full     = uu - corr_a - corr_b;
  assign sel_word = (op_q == OP_MUL) ? full[DATA_W-1:0] : full[PROD_W-1:DATA_W];

  always_comb begin
    pp_ll_d    = pp_ll_q;
    pp_lh_d    = pp_lh_q;
    pp_hl_d    = pp_hl_q;
    pp_hh_d    = pp_hh_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    s1_valid_d = s1_valid_q;
    result_d   = result_q;
    valid_d    = valid_q;
    if (M_en) begin
      pp_ll_d    = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_lo};
      pp_lh_d    = {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, b_hi};
      pp_hl_d    = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_lo};
      pp_hh_d    = {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, b_hi};
      a_d        = E_src1;
      b_d        = E_src2;
      op_d       = E_op;
      a_neg_d    = E_src1[DATA_W-1] & ((E_op == OP_MULXSS) | (E_op == OP_MULXSU));
      b_neg_d    = E_src2[DATA_W-1] & (E_op == OP_MULXSS);
      s1_valid_d = E_valid;
      result_d   = sel_word;
      valid_d    = s1_valid_q;
    end
    // Flush kills valids even while stalled; data registers are unaffected.
    if (M_flush) begin
      s1_valid_d = 1'b0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_ll_q    <= '0;
      pp_lh_q    <= '0;
      pp_hl_q    <= '0;
      pp_hh_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'b00;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      pp_ll_q    <= pp_ll_d;
      pp_lh_q    <= pp_lh_d;
      pp_hl_q    <= pp_hl_d;
      pp_hh_q    <= pp_hh_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      s1_valid_q <= s1_valid_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign W_mul_result = result_q;
  assign W_mul_valid  = valid_q;
  assign W_mul_busy   = s1_valid_q | valid_q;

endmodule

`default_nettype wire

// File: tb/tb_wpa2_nios2_mul_unit.sv
// +----------------------------------------------------------------------------+
// | tb_wpa2_nios2_mul_unit: directed and random checks of wpa2_nios2_mul_unit  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wpa2_nios2_mul_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // 32-bit unit for directed tests
  logic [31:0] a32, b32, res32;
  logic [1:0]  op32;
  logic        v32, en32, fl32, val32, busy32;

  // 8- and 64-bit units for the random sweep
  logic [7:0]  a8, b8, res8;
  logic [63:0] a64, b64, res64;
  logic [1:0]  op8, op64;
  logic        v8, v64, val8, val64, busy8, busy64;
  logic        sw_en, sw_fl;

  wpa2_nios2_mul_unit #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .E_src1(a32), .E_src2(b32), .E_valid(v32),
    .E_op(op32), .M_en(en32), .M_flush(fl32), .W_mul_result(res32),
    .W_mul_valid(val32), .W_mul_busy(busy32));

  wpa2_nios2_mul_unit #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .E_src1(a8), .E_src2(b8), .E_valid(v8),
    .E_op(op8), .M_en(sw_en), .M_flush(sw_fl), .W_mul_result(res8),
    .W_mul_valid(val8), .W_mul_busy(busy8));

  wpa2_nios2_mul_unit #(.DATA_W(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .E_src1(a64), .E_src2(b64), .E_valid(v64),
    .E_op(op64), .M_en(sw_en), .M_flush(sw_fl), .W_mul_result(res64),
    .W_mul_valid(val64), .W_mul_busy(busy64));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend per flavour into 128 bits and multiply directly.
  function automatic logic [63:0] ref_res(input int w, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ax, bx, p;
    logic [63:0]  mask;
    ax   = {64'd0, a};
    bx   = {64'd0, b};
    mask = ~({64{1'b1}} << w);
    if ((op == 2'b01 || op == 2'b10) && a[w-1]) ax = ax | ({128{1'b1}} << w);
    if (op == 2'b01 && b[w-1]) bx = bx | ({128{1'b1}} << w);
    p = ax * bx;
    if (op == 2'b00) return p[63:0] & mask;
    p = p >> w;
    return p[63:0] & mask;
  endfunction

  // Issue one op from a negedge with an empty pipe; checks 2-cycle latency.
  task automatic run_one(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b; en32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    chk({tag, "_lat1_valid"}, {127'd0, val32}, 128'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {127'd0, val32}, 128'd1);
    chk({tag, "_res"}, {96'd0, res32}, {96'd0, exp});
  endtask

  logic        m8_v1, m8_v2, m64_v1, m64_v2;
  logic [63:0] m8_r1, m8_r2, m64_r1, m64_r2;

  initial begin
    reset_n = 1'b0;
    en32 = 1'b1; fl32 = 1'b0; v32 = 1'b1; op32 = 2'b01;
    a32 = 32'h0; b32 = 32'h0;
    sw_en = 1'b1; sw_fl = 1'b0;
    a8 = '0; b8 = '0; op8 = '0; v8 = 1'b0;
    a64 = '0; b64 = '0; op64 = '0; v64 = 1'b0;

    // Reset held with live random operands
    for (int i = 0; i < 3; i++) begin
      a32 = $urandom; b32 = $urandom;
      @(negedge clk);
      chk("rst_valid", {127'd0, val32}, 128'd0);
      chk("rst_res", {96'd0, res32}, 128'd0);
      chk("rst_busy", {127'd0, busy32}, 128'd0);
    end
    v32 = 1'b0;
    reset_n = 1'b1;

    // Flavours and corner values
    run_one("mul_fffe_3",    2'b00, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA);
    run_one("mulxss_fffe_3", 2'b01, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF);
    run_one("mulxsu_fffe_3", 2'b10, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF);
    run_one("mulxuu_fffe_3", 2'b11, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002);
    run_one("mulxss_8000",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mulxuu_8000",   2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mul_8000",      2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    run_one("mulxsu_8000_f", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Back-to-back with a 3-cycle stall after the second issue
    v32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd9;
    @(negedge clk);
    op32 = 2'b11; a32 = 32'h0001_0000; b32 = 32'h0001_0000;
    @(negedge clk);
    chk("b2b_r1_valid", {127'd0, val32}, 128'd1);
    chk("b2b_r1", {96'd0, res32}, 128'h3F);
    en32 = 1'b0; op32 = 2'b00; a32 = 32'h1234_5678; b32 = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {127'd0, val32}, 128'd1);
      chk("stall_res", {96'd0, res32}, 128'h3F);
    end
    en32 = 1'b1;
    @(negedge clk);
    chk("b2b_r2_valid", {127'd0, val32}, 128'd1);
    chk("b2b_r2", {96'd0, res32}, 128'h1);
    op32 = 2'b10; a32 = 32'hFFFF_FFFF; b32 = 32'd5;
    @(negedge clk);
    chk("b2b_r3_valid", {127'd0, val32}, 128'd1);
    chk("b2b_r3", {96'd0, res32}, 128'h2345_6780);
    v32 = 1'b0;
    @(negedge clk);
    chk("b2b_r4_valid", {127'd0, val32}, 128'd1);
    chk("b2b_r4", {96'd0, res32}, 128'hFFFF_FFFF);
    @(negedge clk);
    chk("b2b_nodup", {127'd0, val32}, 128'd0);
    @(negedge clk);
    chk("b2b_idle_busy", {127'd0, busy32}, 128'd0);

    // Flush with one op in stage 1 and a new op arriving together
    v32 = 1'b1; op32 = 2'b11; a32 = 32'd3; b32 = 32'd4;
    @(negedge clk);
    chk("flush_pre_busy", {127'd0, busy32}, 128'd1);
    fl32 = 1'b1; a32 = 32'd5;
    @(negedge clk);
    fl32 = 1'b0; v32 = 1'b0;
    chk("flush_valid0", {127'd0, val32}, 128'd0);
    chk("flush_busy0", {127'd0, busy32}, 128'd0);
    @(negedge clk);
    chk("flush_valid1", {127'd0, val32}, 128'd0);
    @(negedge clk);
    chk("flush_valid2", {127'd0, val32}, 128'd0);

    // Reset with an op in flight
    v32 = 1'b1; op32 = 2'b00; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    v32 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {127'd0, busy32}, 128'd0);
    chk("midrst_res", {96'd0, res32}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid1", {127'd0, val32}, 128'd0);
    @(negedge clk);
    chk("midrst_valid2", {127'd0, val32}, 128'd0);
    run_one("post_rst", 2'b00, 32'd6, 32'd7, 32'd42);

    // Random sweep at DATA_W=8 and 64 against the reference model
    m8_v1 = 1'b0; m8_v2 = 1'b0; m64_v1 = 1'b0; m64_v2 = 1'b0;
    m8_r1 = '0; m8_r2 = '0; m64_r1 = '0; m64_r2 = '0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      chk("sw8_valid", {127'd0, val8}, {127'd0, m8_v2});
      if (m8_v2) chk("sw8_res", {120'd0, res8}, {64'd0, m8_r2});
      chk("sw64_valid", {127'd0, val64}, {127'd0, m64_v2});
      if (m64_v2) chk("sw64_res", {64'd0, res64}, {64'd0, m64_r2});
      m8_v2 = m8_v1; m8_r2 = m8_r1;
      m64_v2 = m64_v1; m64_r2 = m64_r1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      if (i % 11 == 0) begin a8 = 8'h80; a64 = 64'h8000_0000_0000_0000; end
      if (i % 13 == 0) begin b8 = 8'hFF; b64 = '1; end
      op8 = 2'($urandom_range(0, 3));
      op64 = 2'($urandom_range(0, 3));
      v8 = ($urandom_range(0, 3) != 0);
      v64 = ($urandom_range(0, 3) != 0);
      m8_v1 = v8;   m8_r1 = ref_res(8, op8, {56'd0, a8}, {56'd0, b8});
      m64_v1 = v64; m64_r1 = ref_res(64, op64, a64, b64);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
